rgb_frame_fetch: RTL and testbench
==================================

Name: rgb_frame_fetch

Overview:
Streams one 320x240 RGB frame out of external SRAM and feeds it to the VGA display stage.
- Sits downstream of the decoder (milestone 1/2/3 output) and upstream of the VGA controller.
- Reads packed 8-bit RGB words starting at VGA_base_address, then unpacks them to one pixel per handshake.
- Uses a small prefetch FIFO to hide SRAM read latency.

Parameters:
- WIDTH, 320, pixels per row
- HEIGHT, 240, rows per frame
- FIFO_DEPTH, 4, prefetch words held; power of two, >= 4
- RD_LATENCY, 2, cycles from address issue to SRAM_read_data valid

Ports:
- Clock_50  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  one-cycle pulse; begins a frame fetch
- Base_address  in  18  first SRAM word of the RGB frame; sampled on Start
- SRAM_address  out  18  read address
- SRAM_we_n  out  1  tied 1 (read-only block)
- SRAM_read_data  in  16  SRAM data, RD_LATENCY cycles after address issue
- Pixel_ready  in  1  VGA side accepts a pixel
- Pixel_valid  out  1  R/G/B outputs hold a valid pixel
- Pixel_R, Pixel_G, Pixel_B  out  8 each  pixel colour
- Pixel_col  out  9  column index of the current pixel
- Pixel_row  out  8  row index of the current pixel
- Busy  out  1  frame fetch in progress
- Done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset values: SRAM_address=0, SRAM_we_n=1, Pixel_valid=0, R/G/B=0, col=0, row=0, Busy=0, Done=0; FIFO empty; credit=0; in-flight pipe cleared.
- Memory layout: 3 words per 2 pixels, in order {R0,G0},{B0,R1},{G1,B1}; high byte first. A frame is WIDTH*HEIGHT*3/2 = 115200 words.
- Fetch FSM, states S_F_IDLE -> S_F_READ -> S_F_DRAIN -> S_F_IDLE:
  - S_F_IDLE: on Start, load the address counter from Base_address, clear the word count, assert Busy, go to S_F_READ.
  - S_F_READ: issue one read per cycle while fifo_count + in_flight < FIFO_DEPTH. On each issue, increment the address and word count. After the last word is issued, go to S_F_DRAIN.
  - S_F_DRAIN: wait for the last pixel to be accepted, pulse Done for 1 cycle, deassert Busy, return to S_F_IDLE.
- In-flight tracking: a RD_LATENCY-deep valid shift register. Returning data is pushed into the FIFO on the tagged cycle. The credit rule guarantees the FIFO never overflows; any push into a full FIFO is a design error and triggers an assertion.
- Unpack FSM, states S_U_EVEN / S_U_ODD:
  - S_U_EVEN: Pixel_valid requires fifo_count>=2. Outputs R=head[15:8], G=head[7:0], B=next[15:8]. On handshake, pop 1 word and go to S_U_ODD.
  - S_U_ODD: Pixel_valid requires fifo_count>=2. Outputs R=head[7:0], G=next[15:8], B=next[7:0]. On handshake, pop 2 words and go to S_U_EVEN.
  - The FIFO supports pop-1 and pop-2, each concurrent with a push in the same cycle.
- Output handshake:
  - Pixel outputs are combinational from the FIFO head/next entries and the unpack state.
  - Once asserted, valid and data stay stable until Pixel_ready is seen.
  - Pixel_ready while not valid has no effect.
- Counters: col increments on each handshake and wraps WIDTH-1 -> 0, which increments row. After pixel (WIDTH-1, HEIGHT-1), col and row return to 0.
- Latency: the first Pixel_valid is RD_LATENCY+2 cycles after Start (2 reads returned).
- Start while Busy is ignored. Start and Reset in the same cycle: Reset wins.
- Reset mid-frame: everything returns to reset values next cycle. SRAM data returning afterwards is discarded because the valid pipe is cleared.
- Address counter wraps modulo 2^18 (no special case).

Decomposition:
- Package rgb_fetch_pkg holds:
  - enums fetch_state_t {S_F_IDLE,S_F_READ,S_F_DRAIN} and unpack_state_t {S_U_EVEN,S_U_ODD}
  - localparam WORDS_PER_FRAME
- One sub-module: rgb_word_fifo, a FIFO_DEPTH x 16 register FIFO with peek of head/next, push, pop1, pop2, and a count output.

Test Plan:
- Reset, then Start with Base_address=18'd146944, Pixel_ready held 1. Expect pixel 0 = {R0,G0,B0} from words 146944/146945, 76800 handshakes, Done at the end, 115200 reads, last address 262143.
- Pattern word i = i[15:0], Pixel_ready=1. Expect pixel1 = R=0x01, G=0x00, B=0x02 (words 1,2), and col/row wrapping at 319 -> 0 with row 0 -> 1.
- Pixel_ready toggled every other cycle (VGA rate). Expect no data loss, FIFO never overflowing, and valid/data stable while not ready.
- Pixel_ready held 0 for 50 cycles mid-row. Expect reads to stop with fifo_count+in_flight=FIFO_DEPTH and the stream to resume with the correct next pixel.
- Second Start pulse at pixel 100 mid-frame. Expect it to be ignored and the frame to complete normally.
- Reset asserted at pixel 1000. Expect outputs at reset values the next cycle, no Done, and a following Start to restart cleanly from Base_address.

Source files
------------

// File: rtl/rgb_fetch_pkg.sv
// rtl/rgb_fetch_pkg.sv - shared types and frame sizing for the RGB frame fetch block
package rgb_fetch_pkg;

    typedef enum logic [1:0] {S_F_IDLE, S_F_READ, S_F_DRAIN} fetch_state_t;
    typedef enum logic {S_U_EVEN, S_U_ODD} unpack_state_t;

    // Two pixels occupy three 16-bit words.
    function automatic int frame_words(input int width, input int height);
        return (width * height * 3) / 2;
    endfunction

    localparam int WORDS_PER_FRAME = frame_words(320, 240);

endpackage

// File: rtl/rgb_word_fifo.sv
// rtl/rgb_word_fifo.sv - register FIFO with head/next peek, push and pop-1/pop-2
module rgb_word_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [15:0]                i_wdata,
    input  logic                       i_pop1,
    input  logic                       i_pop2,
    output logic [15:0]                o_head,
    output logic [15:0]                o_next,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] w_rd_next;
    logic [1:0]    w_pop_n;

    assign w_rd_next = r_rd + 1'b1;
    assign w_pop_n   = i_pop2 ? 2'd2 : (i_pop1 ? 2'd1 : 2'd0);
    assign o_head    = r_mem[r_rd];
    assign o_next    = r_mem[w_rd_next];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_wdata;
                r_wr        <= r_wr + 1'b1;
            end
            r_rd    <= r_rd + AW'(w_pop_n);
            r_count <= r_count + CW'(i_push) - CW'(w_pop_n);
        end
    end

    // The read credit upstream must make this impossible.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/rgb_frame_fetch.sv
// rtl/rgb_frame_fetch.sv - streams one packed RGB frame from SRAM as one pixel per handshake
module rgb_frame_fetch
    import rgb_fetch_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        Start,
    input  logic [17:0] Base_address,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    input  logic        Pixel_ready,
    output logic        Pixel_valid,
    output logic [7:0]  Pixel_R,
    output logic [7:0]  Pixel_G,
    output logic [7:0]  Pixel_B,
    output logic [8:0]  Pixel_col,
    output logic [7:0]  Pixel_row,
    output logic        Busy,
    output logic        Done
);
    localparam int WORDS = frame_words(WIDTH, HEIGHT);
    localparam int WCW   = $clog2(WORDS + 1);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int LW    = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

    fetch_state_t          r_fstate;
    unpack_state_t         r_ustate;
    logic [17:0]           r_addr;
    logic [WCW-1:0]        r_wcnt;
    logic [RD_LATENCY-1:0] r_vpipe;
    logic                  r_busy;
    logic                  r_done;
    logic [8:0]            r_col;
    logic [7:0]            r_row;

    logic [15:0]   w_head;
    logic [15:0]   w_next;
    logic [CW-1:0] w_count;
    logic [LW-1:0] w_in_flight;
    logic [LW-1:0] w_occ;
    logic          w_issue;
    logic          w_push;
    logic          w_hs;
    logic          w_last_col;
    logic          w_last_pix;
    logic [23:0]   w_pix;

    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_in_flight = w_in_flight + LW'(r_vpipe[i]);
        end
    end

    // Credit: words held plus words still in the SRAM pipe never exceed the FIFO depth.
    assign w_occ      = LW'(w_count) + w_in_flight;
    assign w_issue    = (r_fstate == S_F_READ) && (w_occ < LW'(FIFO_DEPTH));
    assign w_push     = r_vpipe[RD_LATENCY-1];

    assign Pixel_valid = (w_count >= CW'(2));
    assign w_hs        = Pixel_valid && Pixel_ready;
    assign w_last_col  = (r_col == 9'(WIDTH - 1));
    assign w_last_pix  = w_last_col && (r_row == 8'(HEIGHT - 1));

    assign w_pix = (r_ustate == S_U_EVEN) ? {w_head, w_next[15:8]}
                                          : {w_head[7:0], w_next};
    assign {Pixel_R, Pixel_G, Pixel_B} = Pixel_valid ? w_pix : 24'd0;

    assign SRAM_address = r_addr;
    assign SRAM_we_n    = 1'b1;
    assign Pixel_col    = r_col;
    assign Pixel_row    = r_row;
    assign Busy         = r_busy;
    assign Done         = r_done;

    rgb_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (Clock_50),
        .i_rst   (Reset),
        .i_push  (w_push),
        .i_wdata (SRAM_read_data),
        .i_pop1  (w_hs && (r_ustate == S_U_EVEN)),
        .i_pop2  (w_hs && (r_ustate == S_U_ODD)),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_count (w_count)
    );

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            r_fstate <= S_F_IDLE;
            r_addr   <= '0;
            r_wcnt   <= '0;
            r_vpipe  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_vpipe <= (r_vpipe << 1) | RD_LATENCY'(w_issue);
            case (r_fstate)
                S_F_IDLE: begin
                    if (Start) begin
                        r_addr   <= Base_address;
                        r_wcnt   <= '0;
                        r_busy   <= 1'b1;
                        r_fstate <= S_F_READ;
                    end
                end
                S_F_READ: begin
                    if (w_issue) begin
                        r_addr <= r_addr + 18'd1;
                        r_wcnt <= r_wcnt + 1'b1;
                        if (r_wcnt == WCW'(WORDS - 1)) begin
                            r_fstate <= S_F_DRAIN;
                        end
                    end
                end
                S_F_DRAIN: begin
                    if (w_hs && w_last_pix) begin
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_fstate <= S_F_IDLE;
                    end
                end
                default: r_fstate <= S_F_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            r_ustate <= S_U_EVEN;
            r_col    <= '0;
            r_row    <= '0;
        end else if (w_hs) begin
            r_ustate <= (r_ustate == S_U_EVEN) ? S_U_ODD : S_U_EVEN;
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_pix ? 8'd0 : r_row + 8'd1;
            end else begin
                r_col <= r_col + 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_rgb_frame_fetch.sv
// tb/tb_rgb_frame_fetch.sv - directed self-checking bench for rgb_frame_fetch on a reduced frame
module tb_rgb_frame_fetch;
    localparam int W     = 8;
    localparam int H     = 4;
    localparam int NPIX  = W * H;
    localparam int WORDS = NPIX * 3 / 2;

    logic        clk = 1'b0;
    logic        rst, start, ready;
    logic [17:0] base;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_rd;
    logic        pix_valid;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [8:0]  pix_col;
    logic [7:0]  pix_row;
    logic        busy, done;

    logic        pat_id;
    logic [15:0] p1, p2;
    logic [23:0] cap [3];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    rgb_frame_fetch #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(4), .RD_LATENCY(2)) dut (
        .Clock_50       (clk),
        .Reset          (rst),
        .Start          (start),
        .Base_address   (base),
        .SRAM_address   (sram_addr),
        .SRAM_we_n      (sram_we_n),
        .SRAM_read_data (sram_rd),
        .Pixel_ready    (ready),
        .Pixel_valid    (pix_valid),
        .Pixel_R        (pix_r),
        .Pixel_G        (pix_g),
        .Pixel_B        (pix_b),
        .Pixel_col      (pix_col),
        .Pixel_row      (pix_row),
        .Busy           (busy),
        .Done           (done)
    );

    function automatic logic [15:0] mem_word(input logic [17:0] a);
        if (pat_id) return a[15:0];
        return {a[7:0] + 8'h40, ~a[7:0]};
    endfunction

    // Two-cycle SRAM read pipe
    always @(posedge clk) begin
        p1 <= mem_word(sram_addr);
        p2 <= p1;
    end
    assign sram_rd = p2;

    function automatic logic [23:0] exp_pix(input logic [17:0] b, input int p);
        logic [17:0] a0;
        logic [15:0] w0, w1, w2;
        a0 = b + 18'(3 * (p / 2));
        w0 = mem_word(a0);
        w1 = mem_word(a0 + 18'd1);
        w2 = mem_word(a0 + 18'd2);
        return (p % 2 == 0) ? {w0, w1[15:8]} : {w1[7:0], w2};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check(tag, {pix_valid, pix_r, pix_g, pix_b, pix_col, pix_row, busy, done, sram_we_n, sram_addr},
              {1'b0, 24'd0, 9'd0, 8'd0, 1'b0, 1'b0, 1'b1, 18'd0});
    endtask

    // mode: 0 ready=1, 1 ready toggles, 2 ready held low for 50 cycles at pixel 10
    task automatic run_frame(input logic [17:0] b, input int mode, input int reset_at, input int restart_at);
        int pix, cyc, lat, stall_cnt, done_cnt;
        logic prev_stall, restarted;
        logic [23:0] prev_data;
        logic [17:0] addr_mark;
        @(negedge clk);
        base = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pix = 0; cyc = 0; lat = -1; stall_cnt = 0; done_cnt = 0;
        prev_stall = 1'b0; restarted = 1'b0; prev_data = '0; addr_mark = '0;
        while (cyc < 2000) begin
            if (reset_at >= 0 && pix == reset_at) begin
                ready = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset_state("mid_reset");
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check("post_reset_quiet", {pix_valid, done, busy}, 3'b000);
                end
                return;
            end
            if (pix_valid && lat < 0) lat = cyc;
            if (prev_stall) check("hold", {pix_valid, pix_r, pix_g, pix_b}, {1'b1, prev_data});
            if (done) begin
                done_cnt++;
                break;
            end
            start = (pix == restart_at && !restarted);
            if (start) restarted = 1'b1;
            case (mode)
                1:       ready = cyc[0];
                2:       ready = !(pix >= 10 && stall_cnt < 50);
                default: ready = 1'b1;
            endcase
            if (mode == 2 && pix >= 10 && stall_cnt < 50) begin
                if (stall_cnt == 10) addr_mark = sram_addr;
                if (stall_cnt == 49) check("stall_addr", sram_addr, addr_mark);
                stall_cnt++;
            end
            if (pix_valid && ready) begin
                check("pixel", {pix_r, pix_g, pix_b, pix_col, pix_row},
                      {exp_pix(b, pix), 9'(pix % W), 8'(pix / W)});
                if (pix == 0) cap[0] = {pix_r, pix_g, pix_b};
                if (pix == 1) cap[1] = {pix_r, pix_g, pix_b};
                if (pix == NPIX - 1) cap[2] = {pix_r, pix_g, pix_b};
                pix++;
            end
            prev_stall = pix_valid && !ready;
            prev_data  = {pix_r, pix_g, pix_b};
            @(negedge clk);
            if (start) begin
                start = 1'b0;
                check("busy_after_restart", busy, 1'b1);
            end
            cyc++;
        end
        check("done_seen", done_cnt, 1);
        check("npix", pix, NPIX);
        if (mode == 0) check("latency", lat, 4);
        ready = 1'b0;
        @(negedge clk);
        check("frame_end", {done, busy, pix_valid, pix_col, pix_row, sram_addr},
              {3'b000, 9'd0, 8'd0, 18'(b + 18'(WORDS))});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b0; base = '0; pat_id = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("reset_beats_start", busy, 1'b0);

        run_frame(18'd262096, 0, -1, -1);
        check("a_pix0", cap[0], 24'h102F11);
        check("a_pix1", cap[1], 24'h2E122D);
        check("a_last_pix", cap[2], 24'h013F00);

        pat_id = 1'b1;
        run_frame(18'd0, 0, -1, -1);
        check("b_pix0", cap[0], 24'h000000);
        check("b_pix1", cap[1], 24'h010002);

        pat_id = 1'b0;
        run_frame(18'd1000, 1, -1, -1);
        run_frame(18'd5000, 2, -1, -1);
        run_frame(18'd777, 0, -1, 10);
        run_frame(18'd3000, 0, 20, -1);
        run_frame(18'd3000, 0, -1, -1);
        check("restart_pix0", cap[0], exp_pix(18'd3000, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
